oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/gb_pkg.sv | 23 ++
 rtl/oam_dma.sv | 142 ++++++++++++++
 tb/tb_oam_dma.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared constants, state encoding and the echo-RAM page fold used by the
// OAM DMA engine.
package gb_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN      = 160;
  localparam logic [7:0]  ECHO_PAGE_LO = 8'hE0;
  localparam logic [7:0]  ECHO_FOLD    = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_XFER,
    ST_FLUSH
  } dma_state_e;

  // Source pages at or above $E0 sit in echo RAM and alias onto $C0-$DF.
  function automatic logic [7:0] dmaPage(input logic [7:0] src);
    return (src < ECHO_PAGE_LO) ? src : (src - ECHO_FOLD);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to $FF46 copies BYTES bytes from page
// {src,$00} (echo RAM folded down by $20) into OAM, one byte per
// CYC_PER_BYTE clocks, after a CYC_PER_BYTE-clock start-up delay.
// Optional build macro: OAM_DMA_BUS_LOCK_EN -- when defined, the CPU is locked
// out while a transfer is active (cpu_blocked = active, cpu_do reads $FF and
// $FF46 writes are dropped); when undefined, cpu_blocked is tied low.
module oam_dma
  import gb_pkg::*;
#(
  parameter int BYTES        = OAM_LEN,
  parameter int CYC_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        active,
  output logic        cpu_blocked
);

  localparam int             PW         = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(CYC_PER_BYTE - 1);
  localparam logic [7:0]     IDX_LAST   = 8'(BYTES - 1);

  dma_state_e    state_q;
  logic [7:0]    src_q;
  logic [7:0]    idx_q;
  logic [PW-1:0] phase_q;
  logic          wrPrev_q;
  logic          dma_rd_q;
  logic [15:0]   dma_addr_q;
  logic          oam_wr_q;
  logic [7:0]    oam_addr_q;
  logic [7:0]    oam_data_q;
  logic          active_q;

  logic          busLock;
  logic          wrLevel;
  logic          trigger;

`ifdef OAM_DMA_BUS_LOCK_EN
  assign busLock = active_q;
`else
  assign busLock = 1'b0;
`endif

  assign wrLevel = cpu_sel & cpu_wr & ~busLock;
  assign trigger = wrLevel & ~wrPrev_q;

  assign cpu_do      = busLock ? 8'hFF : src_q;
  assign cpu_blocked = busLock;
  assign dma_rd      = dma_rd_q;
  assign dma_addr    = dma_addr_q;
  assign oam_wr      = oam_wr_q;
  assign oam_addr    = oam_addr_q;
  assign oam_data    = oam_data_q;
  assign active      = active_q;

  // Transfer sequencer: a fresh $FF46 write restarts from any state, otherwise
  // START waits one machine cycle, XFER reads one byte per machine cycle and
  // FLUSH carries the final OAM write before dropping back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= 8'hFF;
      idx_q      <= 8'd0;
      phase_q    <= '0;
      wrPrev_q   <= wrLevel;
      dma_rd_q   <= 1'b0;
      dma_addr_q <= 16'h0000;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= 8'd0;
      oam_data_q <= 8'd0;
      active_q   <= 1'b0;
    end else begin
      wrPrev_q <= wrLevel;
      oam_wr_q <= 1'b0;
      if (trigger) begin
        src_q    <= cpu_di;
        state_q  <= ST_START;
        idx_q    <= 8'd0;
        phase_q  <= '0;
        dma_rd_q <= 1'b0;
        active_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            dma_rd_q <= 1'b0;
            active_q <= 1'b0;
          end
          ST_START: begin
            if (phase_q == PHASE_LAST) begin
              state_q    <= ST_XFER;
              phase_q    <= '0;
              idx_q      <= 8'd0;
              dma_rd_q   <= 1'b1;
              dma_addr_q <= {dmaPage(src_q), 8'd0};
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          ST_XFER: begin
            if (phase_q == PHASE_LAST) begin
              oam_data_q <= dma_data;
              oam_addr_q <= idx_q;
              oam_wr_q   <= 1'b1;
              phase_q    <= '0;
              if (idx_q == IDX_LAST) begin
                state_q  <= ST_FLUSH;
                dma_rd_q <= 1'b0;
              end else begin
                idx_q      <= idx_q + 8'd1;
                dma_addr_q <= {dmaPage(src_q), idx_q + 8'd1};
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
          ST_FLUSH: begin
            state_q  <= ST_IDLE;
            idx_q    <= 8'd0;
            active_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_IDLE;
            dma_rd_q <= 1'b0;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a random 64 KiB memory feeds dma_data, and
// an expected list of OAM writes (cycle, index, byte) is built from the
// transfer timing rules and compared with every observed oam_wr pulse.
module tb_oam_dma;

  localparam int BYTES = 160;
  localparam int CPB   = 4;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        active;
  logic        cpu_blocked;

  logic [7:0]  mem [0:65535];

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t evQ[$];
  ev_t expQ[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int rdCount = 0;
  logic [15:0] rdFirst = 16'h0;
  logic [15:0] rdLast = 16'h0;
  int blockBad = 0;

  oam_dma #(.BYTES(BYTES), .CYC_PER_BYTE(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_sel     (cpu_sel),
    .cpu_wr      (cpu_wr),
    .cpu_di      (cpu_di),
    .cpu_do      (cpu_do),
    .dma_rd      (dma_rd),
    .dma_addr    (dma_addr),
    .dma_data    (dma_data),
    .oam_wr      (oam_wr),
    .oam_addr    (oam_addr),
    .oam_data    (oam_data),
    .active      (active),
    .cpu_blocked (cpu_blocked)
  );

  assign dma_data = mem[dma_addr];

  always #5 clk = ~clk;

  // Edge counter: between edges it holds the index of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: logs every OAM write, source-read span and lock-out behaviour.
  always @(negedge clk) begin
    logic expBlk;
    ev_t ev;
    if (oam_wr === 1'b1) begin
      ev.cyc  = cyc;
      ev.addr = int'(oam_addr);
      ev.data = int'(oam_data);
      evQ.push_back(ev);
    end
    if (dma_rd === 1'b1) begin
      if (rdCount == 0) rdFirst = dma_addr;
      rdLast = dma_addr;
      rdCount++;
    end
`ifdef OAM_DMA_BUS_LOCK_EN
    expBlk = active;
`else
    expBlk = 1'b0;
`endif
    if (cpu_blocked !== expBlk) blockBad++;
  end

  function automatic logic [7:0] modelPage(input logic [7:0] s);
    if (s >= 8'hE0) return s - 8'h20;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is sampled on the next rising edge.
  task automatic applyStimulus(input logic [7:0] d, input int holdClks, output int trigEdge);
    cpu_sel  = 1'b1;
    cpu_wr   = 1'b1;
    cpu_di   = d;
    trigEdge = cyc + 1;
    repeat (holdClks) @(negedge clk);
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
  endtask

  // Byte i of a transfer triggered at edge e is written in cycle e+8+4i,
  // unless a restart or reset is sampled at or before that edge.
  task automatic expectTransfer(input int e, input logic [7:0] src, input int abortEdge);
    ev_t ev;
    for (int i = 0; i < BYTES; i++) begin
      if (e + 2 * CPB + CPB * i < abortEdge) begin
        ev.cyc  = e + 2 * CPB + CPB * i;
        ev.addr = i;
        ev.data = int'(mem[{modelPage(src), 8'(i)}]);
        expQ.push_back(ev);
      end
    end
  endtask

  task automatic compareEvents(input string tag);
    int n;
    checkOutput({tag, "_count"}, evQ.size(), expQ.size());
    n = (evQ.size() < expQ.size()) ? evQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_cyc"}, evQ[i].cyc, expQ[i].cyc);
      checkOutput({tag, "_addr"}, evQ[i].addr, expQ[i].addr);
      checkOutput({tag, "_data"}, evQ[i].data, expQ[i].data);
    end
    evQ.delete();
    expQ.delete();
  endtask

  task automatic waitIdle(input int budget, output int fallCyc);
    int n = 0;
    while (active !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleWithinBudget", (n < budget), 1);
    fallCyc = cyc;
  endtask

  task automatic clearLogs();
    evQ.delete();
    expQ.delete();
    rdCount = 0;
  endtask

  initial begin
    int e, e2, fallCyc, hold;
    logic [7:0] src;
    logic [7:0] expDo;

    reset   = 1'b1;
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
    cpu_di  = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_cpuDo", cpu_do, 8'hFF);
    checkOutput("rst_active", active, 1'b0);
    checkOutput("rst_dmaRd", dma_rd, 1'b0);
    checkOutput("rst_oamWr", oam_wr, 1'b0);
    checkOutput("rst_oamAddr", oam_addr, 8'h00);
    checkOutput("rst_oamData", oam_data, 8'h00);
    checkOutput("rst_cpuBlocked", cpu_blocked, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Page $C0 holding i^$5A: timing of first/last write and active fall.
    for (int i = 0; i < BYTES; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
    clearLogs();
    applyStimulus(8'hC0, 1, e);
    expectTransfer(e, 8'hC0, NEVER);
    waitIdle(2000, fallCyc);
    checkOutput("c0_activeFall", fallCyc, e + 1 + (BYTES + 1) * CPB);
    compareEvents("c0");
    repeat (3) @(negedge clk);

    // Echo page $E1 folds onto $C1; readback shows the written value.
    clearLogs();
    applyStimulus(8'hE1, 1, e);
`ifdef OAM_DMA_BUS_LOCK_EN
    expDo = 8'hFF;
`else
    expDo = 8'hE1;
`endif
    checkOutput("e1_cpuDoBusy", cpu_do, expDo);
    expectTransfer(e, 8'hE1, NEVER);
    waitIdle(2000, fallCyc);
    checkOutput("e1_cpuDoIdle", cpu_do, 8'hE1);
    checkOutput("e1_rdCount", rdCount, BYTES * CPB);
    checkOutput("e1_rdFirst", rdFirst, 16'hC100);
    checkOutput("e1_rdLast", rdLast, 16'hC19F);
    compareEvents("e1");
    repeat (2) @(negedge clk);

    // Random source pages and random write-strobe lengths.
    for (int k = 0; k < 3; k++) begin
      src  = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 3);
      clearLogs();
      applyStimulus(src, hold, e);
      expectTransfer(e, src, NEVER);
      waitIdle(2000, fallCyc);
      checkOutput("rnd_activeFall", fallCyc, e + 1 + (BYTES + 1) * CPB);
      checkOutput("rnd_rdFirst", rdFirst, {modelPage(src), 8'h00});
      compareEvents("rnd");
      repeat (2) @(negedge clk);
    end

    // Restart with $D0 midway through byte 50 of a $C0 transfer.
    clearLogs();
    applyStimulus(8'hC0, 1, e);
    while (cyc < e + 205) @(negedge clk);
    applyStimulus(8'hD0, 1, e2);
`ifdef OAM_DMA_BUS_LOCK_EN
    expectTransfer(e, 8'hC0, NEVER);
`else
    expectTransfer(e, 8'hC0, e2);
    expectTransfer(e2, 8'hD0, NEVER);
    checkOutput("abort_expectedTotal", expQ.size(), 210);
`endif
    waitIdle(3000, fallCyc);
    compareEvents("abort");
    repeat (2) @(negedge clk);

    // Reset during byte 80: writes stop and outputs clear on the next clock.
    clearLogs();
    applyStimulus(8'h80, 1, e);
    while (cyc < e + 324) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRst_active", active, 1'b0);
    checkOutput("midRst_cpuDo", cpu_do, 8'hFF);
    checkOutput("midRst_oamWr", oam_wr, 1'b0);
    checkOutput("midRst_dmaRd", dma_rd, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    expectTransfer(e, 8'h80, e + 325);
    repeat (700) @(negedge clk);
    checkOutput("midRst_stillIdle", active, 1'b0);
    compareEvents("midRst");

    // A write coinciding with reset is discarded.
    clearLogs();
    reset   = 1'b1;
    cpu_sel = 1'b1;
    cpu_wr  = 1'b1;
    cpu_di  = 8'h33;
    @(negedge clk);
    reset   = 1'b0;
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rstWr_cpuDo", cpu_do, 8'hFF);
    checkOutput("rstWr_active", active, 1'b0);
    compareEvents("rstWr");

    // Lock-out output over the whole run.
    checkOutput("cpuBlocked_track", blockBad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
